// File: rtl/seg_scan_display.sv
// Four-digit multiplexed common-anode seven-segment driver with frame-aligned commit.
// Optional feature macro: LEADING_ZERO_BLANK_EN (auto-blank leading zero digits).
module seg_scan_display #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] hex_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic        frame_done
);

    localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [1:0]    dig_q, dig_d;
    logic          pend_q, pend_d;
    logic [15:0]   sh_hex_q, sh_hex_d, act_hex_q, act_hex_d;
    logic [3:0]    sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
    logic [3:0]    sh_bl_q, sh_bl_d, act_bl_q, act_bl_d;
    logic [3:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic          fd_q;
    logic          tick, boundary;
    logic [3:0]    nib, lz, eff_bl;

    function automatic logic [6:0] font(input logic [3:0] v);
        case (v)
            4'h0: font = 7'h40;  4'h1: font = 7'h79;
            4'h2: font = 7'h24;  4'h3: font = 7'h30;
            4'h4: font = 7'h19;  4'h5: font = 7'h12;
            4'h6: font = 7'h02;  4'h7: font = 7'h78;
            4'h8: font = 7'h00;  4'h9: font = 7'h10;
            4'hA: font = 7'h08;  4'hB: font = 7'h03;
            4'hC: font = 7'h46;  4'hD: font = 7'h21;
            4'hE: font = 7'h06;  default: font = 7'h0E;
        endcase
    endfunction

    always_comb begin
        tick      = (pcnt_q == LAST);
        boundary  = tick && (dig_q == 2'd3);
        pcnt_d    = tick ? '0 : pcnt_q + PW'(1);
        dig_d     = tick ? dig_q + 2'd1 : dig_q;
        sh_hex_d  = sh_hex_q;
        sh_dp_d   = sh_dp_q;
        sh_bl_d   = sh_bl_q;
        act_hex_d = act_hex_q;
        act_dp_d  = act_dp_q;
        act_bl_d  = act_bl_q;
        pend_d    = pend_q;
        if (load) begin
            sh_hex_d = hex_in;
            sh_dp_d  = dp_in;
            sh_bl_d  = blank_in;
        end
        // A load coinciding with the boundary bypasses the shadow entirely
        if (boundary) begin
            pend_d = 1'b0;
            if (load) begin
                act_hex_d = hex_in;
                act_dp_d  = dp_in;
                act_bl_d  = blank_in;
            end else if (pend_q) begin
                act_hex_d = sh_hex_q;
                act_dp_d  = sh_dp_q;
                act_bl_d  = sh_bl_q;
            end
        end else if (load) begin
            pend_d = 1'b1;
        end
    end

    always_comb begin
        nib = act_hex_q[dig_q*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        lz[3] = (act_hex_q[15:12] == 4'h0);
        lz[2] = lz[3] && (act_hex_q[11:8] == 4'h0);
        lz[1] = lz[2] && (act_hex_q[7:4] == 4'h0);
        lz[0] = 1'b0;
`else
        lz = 4'b0000;
`endif
        eff_bl = act_bl_q | lz;
        if (eff_bl[dig_q]) begin
            an_d  = 4'b1111;
            seg_d = 8'hFF;
        end else begin
            an_d  = ~(4'b0001 << dig_q);
            seg_d = {~act_dp_q[dig_q], font(nib)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q    <= '0;
            dig_q     <= 2'd0;
            pend_q    <= 1'b0;
            sh_hex_q  <= 16'h0;
            sh_dp_q   <= 4'h0;
            sh_bl_q   <= 4'h0;
            act_hex_q <= 16'h0;
            act_dp_q  <= 4'h0;
            act_bl_q  <= 4'h0;
            an_q      <= 4'b1111;
            seg_q     <= 8'hFF;
            fd_q      <= 1'b0;
        end else begin
            pcnt_q    <= pcnt_d;
            dig_q     <= dig_d;
            pend_q    <= pend_d;
            sh_hex_q  <= sh_hex_d;
            sh_dp_q   <= sh_dp_d;
            sh_bl_q   <= sh_bl_d;
            act_hex_q <= act_hex_d;
            act_dp_q  <= act_dp_d;
            act_bl_q  <= act_bl_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            fd_q      <= boundary;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display with SCAN_DIV=4: cycle-indexed reference model plus directed literal checks.
module tb_seg_scan_display;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [15:0] hex_in = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank_in = 4'h0;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame_done;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    seg_scan_display #(.SCAN_DIV(D)) dut (
        .clk(clk), .rst(rst), .load(load), .hex_in(hex_in), .dp_in(dp_in),
        .blank_in(blank_in), .an(an), .seg(seg), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Reference: edge k after reset shows digit (k/D)%4; edge k is a frame boundary when k%(4D)==4D-1
    logic [7:0] font_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    int          mk;
    logic [15:0] m_hex, s_hex;
    logic [3:0]  m_dp, s_dp, m_bl, s_bl;
    bit          m_pend;
    logic [3:0]  e_an;
    logic [7:0]  e_seg;
    logic        e_fd;

    function automatic bit lz_dark(input logic [15:0] h, input int d);
        int msd = 0;
        for (int i = 0; i < 4; i++) if (((h >> (4 * i)) & 16'hF) != 0) msd = i;
`ifdef LEADING_ZERO_BLANK_EN
        return d > msd;
`else
        return (msd < 0);
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mk = 0; m_pend = 0;
            m_hex = 0; s_hex = 0; m_dp = 0; s_dp = 0; m_bl = 0; s_bl = 0;
            e_an = 4'hF; e_seg = 8'hFF; e_fd = 0;
        end else begin
            int d;
            bit bnd;
            d = (mk / D) % 4;
            if (m_bl[d] || lz_dark(m_hex, d)) begin
                e_an = 4'hF; e_seg = 8'hFF;
            end else begin
                e_an = 4'hF & ~(4'(1) << d);
                e_seg = font_tab[(m_hex >> (4 * d)) & 16'hF];
                if (m_dp[d]) e_seg[7] = 1'b0;
            end
            bnd = (mk % (4 * D)) == (4 * D - 1);
            e_fd = bnd;
            if (load) begin s_hex = hex_in; s_dp = dp_in; s_bl = blank_in; end
            if (bnd) begin
                if (load) begin m_hex = hex_in; m_dp = dp_in; m_bl = blank_in; end
                else if (m_pend) begin m_hex = s_hex; m_dp = s_dp; m_bl = s_bl; end
                m_pend = 0;
            end else if (load) m_pend = 1;
            mk++;
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t cyc=%0d act=%h exp=%h", nm, $time, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_an", 16'(an), 16'(e_an));
            chk("cmp_seg", 16'(seg), 16'(e_seg));
            chk("cmp_fd", 16'(frame_done), 16'(e_fd));
        end
    end

    task automatic lit(input string nm, input logic [3:0] xan, input logic [7:0] xseg);
        chk({nm, "_an"}, 16'(an), 16'(xan));
        chk({nm, "_seg"}, 16'(seg), 16'(xseg));
        chk({nm, "_model_seg"}, 16'(e_seg), 16'(xseg));
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_load(input logic [15:0] h, input logic [3:0] dp, input logic [3:0] bl);
        load = 1'b1; hex_in = h; dp_in = dp; blank_in = bl;
        step();
        load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 rst = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        lit("reset", 4'hF, 8'hFF);
        chk("reset_fd", 16'(frame_done), 16'h0);
        rst = 1'b0;
        cyc = 0;

        goto(1);  lit("first", 4'hE, 8'hC0);
        goto(5);  lit("dig1", 4'hD, 8'hC0);
        goto(9);  lit("dig2", 4'hB, 8'hC0);
        goto(13); lit("dig3", 4'h7, 8'hC0);
        goto(16); chk("fd_pulse", 16'(frame_done), 16'h1);
        goto(17); chk("fd_low", 16'(frame_done), 16'h0);

        do_load(16'h1234, 4'b0100, 4'b0000);
        goto(29); lit("pre_commit", 4'h7, 8'hC0);
        goto(33); lit("c_d0", 4'hE, 8'h99);
        goto(37); lit("c_d1", 4'hD, 8'hB0);
        goto(41); lit("c_d2", 4'hB, 8'h24);
        goto(45); lit("c_d3", 4'h7, 8'hF9);

        goto(50); do_load(16'hAAAA, 4'b0000, 4'b0000);
        goto(63); do_load(16'hBEEF, 4'b0000, 4'b0000);
        goto(65); lit("ow_d0", 4'hE, 8'h8E);
        goto(77); lit("ow_d3", 4'h7, 8'h83);

        goto(66) ; do_load(16'h1234, 4'b0000, 4'b1010);
        goto(81); lit("bl_d0", 4'hE, 8'h99);
        goto(85); lit("bl_d1", 4'hF, 8'hFF);
        goto(89); lit("bl_d2", 4'hB, 8'hA4);
        goto(93); lit("bl_d3", 4'hF, 8'hFF);

        goto(82); do_load(16'h0050, 4'b0000, 4'b0000);
        goto(97);  lit("lz_d0", 4'hE, 8'hC0);
        goto(101); lit("lz_d1", 4'hD, 8'h92);
`ifdef LEADING_ZERO_BLANK_EN
        goto(105); lit("lz_d2", 4'hF, 8'hFF);
        goto(109); lit("lz_d3", 4'hF, 8'hFF);
`else
        goto(105); lit("lz_d2", 4'hB, 8'hC0);
        goto(109); lit("lz_d3", 4'h7, 8'hC0);
`endif

        goto(116); do_load(16'h9999, 4'b1111, 4'b0000);
        goto(122);
        #2 rst = 1'b1;
        #1 lit("async_rst", 4'hF, 8'hFF);
        chk("async_rst_fd", 16'(frame_done), 16'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        goto(1);  lit("rr_first", 4'hE, 8'hC0);
        goto(17); lit("rr_f1", 4'hE, 8'hC0);
        goto(33); lit("rr_f2", 4'hE, 8'hC0);
        goto(45); lit("rr_d3", 4'h7, 8'hC0);
        goto(48);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
